// File: rtl/player_ctrl_arbiter_if.sv
// Command-input and player-state bundle shared by the arbiter and whatever drives it.
// master drives the received bytes and button pulses; slave is the arbiter itself.
interface player_ctrl_arbiter_if;
  logic        bt_valid;
  logic [7:0]  bt_data;
  logic        btn_prev;
  logic        btn_next;
  logic        btn_vdn;
  logic        btn_vup;
  logic [15:0] volume;
  logic [2:0]  current;
  logic        cmd_accept;
  logic        bt_drop;
  logic        busy;

  modport master (
    output bt_valid, bt_data, btn_prev, btn_next, btn_vdn, btn_vup,
    input  volume, current, cmd_accept, bt_drop, busy
  );

  modport slave (
    input  bt_valid, bt_data, btn_prev, btn_next, btn_vdn, btn_vup,
    output volume, current, cmd_accept, bt_drop, busy
  );
endinterface

// File: rtl/player_ctrl_arbiter.sv
// Arbitrates Bluetooth command bytes (4-deep FIFO) and front-panel buttons into track/volume
// updates with a hold-off after each one. Define PLAYER_ARB_RR_EN for round-robin arbitration.
module player_ctrl_arbiter #(
  parameter int unsigned DELAY_TIME = 5000000,
  parameter int unsigned NUM_TRACKS = 5
) (
  input logic                  clk,
  input logic                  rst,
  player_ctrl_arbiter_if.slave bus
);

  localparam int unsigned     CntW      = (DELAY_TIME == 0) ? 1 : $clog2(DELAY_TIME + 1);
  localparam logic [CntW-1:0] CntMax    = CntW'(DELAY_TIME);
  localparam logic [2:0]      LastTrack = 3'(NUM_TRACKS - 1);
  // Button commands share their encoding with the pending-bit index.
  localparam logic [3:0]      CmdPrev   = 4'd0;
  localparam logic [3:0]      CmdNext   = 4'd1;
  localparam logic [3:0]      CmdVdn    = 4'd2;
  localparam logic [3:0]      CmdVup    = 4'd3;

  typedef enum logic [1:0] {StIdle, StApply, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dec_hit, stage_valid_q;
  logic [3:0]      dec_cmd, stage_cmd_q, sel_cmd;
  logic [3:0]      fifo_mem_q [4];
  logic [1:0]      wr_ptr_q, rd_ptr_q, btn_idx, grant_idx_q;
  logic [2:0]      count_q, cur_q, cur_d;
  logic [7:0]      vol_q, vol_d;
  logic [3:0]      pend_q, btn_clr;
  logic            fifo_full, fifo_req, fifo_push, fifo_pop;
  logic            btn_req, pick_btn, start, grant_btn_q;

  always_comb begin
    dec_hit = 1'b1;
    dec_cmd = CmdPrev;
    if (bus.bt_data == 8'hB1)                    dec_cmd = CmdPrev;
    else if (bus.bt_data == 8'hB2)               dec_cmd = CmdNext;
    else if (bus.bt_data == 8'hB3)               dec_cmd = CmdVdn;
    else if (bus.bt_data == 8'hB4)               dec_cmd = CmdVup;
    else if (bus.bt_data < 8'(NUM_TRACKS))       dec_cmd = {1'b1, bus.bt_data[2:0]};
    else                                         dec_hit = 1'b0;
  end

  assign fifo_full  = (count_q == 3'd4);
  assign fifo_req   = (count_q != 3'd0);
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign fifo_push  = stage_valid_q & (~fifo_full | fifo_pop);
  assign bus.bt_drop = stage_valid_q & fifo_full & ~fifo_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid_q <= 1'b0;
      stage_cmd_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pend_q        <= '0;
    end else begin
      stage_valid_q <= bus.bt_valid & dec_hit;
      stage_cmd_q   <= dec_cmd;
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + 3'(fifo_push) - 3'(fifo_pop);
      pend_q  <= (pend_q | {bus.btn_vup, bus.btn_vdn, bus.btn_next, bus.btn_prev}) & ~btn_clr;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem_q[wr_ptr_q] <= stage_cmd_q;
  end

  assign btn_req = |pend_q;

  always_comb begin
    btn_idx = 2'd3;
    if (pend_q[0])      btn_idx = 2'd0;
    else if (pend_q[1]) btn_idx = 2'd1;
    else if (pend_q[2]) btn_idx = 2'd2;
  end

`ifdef PLAYER_ARB_RR_EN
  logic last_fifo_q;

  assign pick_btn = btn_req & (~fifo_req | last_fifo_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       last_fifo_q <= 1'b1;
    else if (start) last_fifo_q <= ~pick_btn;
  end
`else
  assign pick_btn = btn_req;
`endif

  assign sel_cmd = pick_btn ? {2'b00, btn_idx} : fifo_mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle:  if (btn_req | fifo_req) state_d = StApply;
      StApply: state_d = StHold;
      StHold: begin
        if (cnt_q == CntMax) state_d = StIdle;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start          = 1'b0;
    fifo_pop       = 1'b0;
    btn_clr        = '0;
    bus.cmd_accept = 1'b0;
    bus.busy       = 1'b1;
    unique case (state_q)
      StIdle: begin
        bus.busy = 1'b0;
        start    = btn_req | fifo_req;
      end
      StApply: begin
        bus.cmd_accept = 1'b1;
        if (grant_btn_q) btn_clr[grant_idx_q] = 1'b1;
        else             fifo_pop             = 1'b1;
      end
      default: ;
    endcase
  end

  // The granted command takes effect on the IDLE->APPLY edge so it is visible with cmd_accept.
  always_comb begin
    vol_d = vol_q;
    cur_d = cur_q;
    if (start) begin
      unique case (sel_cmd)
        CmdPrev: cur_d = (cur_q == 3'd0) ? LastTrack : cur_q - 3'd1;
        CmdNext: cur_d = (cur_q == LastTrack) ? 3'd0 : cur_q + 3'd1;
        CmdVdn:  vol_d = (vol_q == 8'h00) ? vol_q : vol_q - 8'h10;
        CmdVup:  vol_d = (vol_q == 8'hF0) ? vol_q : vol_q + 8'h10;
        default: cur_d = sel_cmd[2:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vol_q       <= 8'h80;
      cur_q       <= '0;
      grant_btn_q <= 1'b0;
      grant_idx_q <= '0;
    end else begin
      vol_q <= vol_d;
      cur_q <= cur_d;
      if (start) begin
        grant_btn_q <= pick_btn;
        grant_idx_q <= btn_idx;
      end
    end
  end

  assign bus.volume  = {vol_q, vol_q};
  assign bus.current = cur_q;

endmodule

// File: tb/tb_player_ctrl_arbiter.sv
// Bench for player_ctrl_arbiter: a queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_player_ctrl_arbiter;
  localparam int DELAY = 8;
  localparam int NTRK  = 5;
`ifdef PLAYER_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic clk;
  logic rst;
  player_ctrl_arbiter_if bus ();

  player_ctrl_arbiter #(
    .DELAY_TIME(DELAY),
    .NUM_TRACKS(NTRK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  int drop_cnt = 0;
  int busy_cnt = 0;
  bit cmp_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Reference model: edge counter, byte queue, pending-button set, and the player state.
  int         ecnt, last_g, m_vol, m_cur, clr_idx;
  logic [7:0] q[$];
  logic [7:0] staged_b;
  bit   [3:0] pend;
  bit         staged_v, pop_due, clr_due, last_fifo;

  function automatic bit is_cmd(input logic [7:0] b);
    return (b >= 8'hB1 && b <= 8'hB4) || (b < 8'(NTRK));
  endfunction

  task automatic model_reset();
    ecnt = 0; last_g = -1000; q.delete(); pend = '0; staged_v = 0; staged_b = '0;
    pop_due = 0; clr_due = 0; clr_idx = 0; m_vol = 128; m_cur = 0; last_fifo = 1;
  endtask

  task automatic model_apply(input logic [7:0] c);
    case (c)
      8'hB1:   m_cur = (m_cur + NTRK - 1) % NTRK;
      8'hB2:   m_cur = (m_cur + 1) % NTRK;
      8'hB3:   m_vol = (m_vol >= 16) ? m_vol - 16 : 0;
      8'hB4:   m_vol = (m_vol + 16 > 240) ? 240 : m_vol + 16;
      default: m_cur = int'(c);
    endcase
  endtask

  task automatic model_step();
    bit pop_now, clr_now, breq, freq, use_btn;
    int ci, k;
    ecnt++;
    pop_now = pop_due; clr_now = clr_due; ci = clr_idx;
    pop_due = 0; clr_due = 0;
    breq = (pend != 0);
    freq = (q.size() != 0);
    // Grants are spaced DELAY+3 edges apart: one APPLY cycle, DELAY+1 HOLD cycles, one IDLE.
    if ((ecnt - last_g) >= DELAY + 3 && (breq || freq)) begin
      use_btn = breq && (!freq || !RrEn || last_fifo);
      if (use_btn) begin
        k = 0;
        while (!pend[k]) k++;
        clr_due = 1; clr_idx = k;
        model_apply(8'hB1 + 8'(k));
      end else begin
        pop_due = 1;
        model_apply(q[0]);
      end
      last_fifo = !use_btn;
      last_g = ecnt;
    end
    if (pop_now) void'(q.pop_front());
    pend = pend | {bus.btn_vup, bus.btn_vdn, bus.btn_next, bus.btn_prev};
    if (clr_now) pend[ci] = 1'b0;
    if (staged_v && q.size() < 4) q.push_back(staged_b);
    staged_v = bus.bt_valid && is_cmd(bus.bt_data);
    staged_b = bus.bt_data;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  initial begin
    logic [7:0] mv;
    forever begin
      @(negedge clk);
      if (rst && cmp_en) begin
        mv = m_vol[7:0];
        chk("volume", bus.volume, {mv, mv});
        chk("current", bus.current, m_cur[2:0]);
        chk("cmd_accept", bus.cmd_accept, (ecnt == last_g) ? 1 : 0);
        chk("busy", bus.busy, ((ecnt - last_g) <= DELAY + 1) ? 1 : 0);
        chk("bt_drop", bus.bt_drop, (staged_v && q.size() == 4 && !pop_due) ? 1 : 0);
        if (bus.cmd_accept) acc_cnt++;
        if (bus.bt_drop)    drop_cnt++;
        if (bus.busy)       busy_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bt(input logic [7:0] b);
    bus.bt_valid = 1'b1;
    bus.bt_data  = b;
    tick(1);
    bus.bt_valid = 1'b0;
  endtask

  task automatic btn(input int i);
    bus.btn_prev = (i == 0);
    bus.btn_next = (i == 1);
    bus.btn_vdn  = (i == 2);
    bus.btn_vup  = (i == 3);
    tick(1);
    {bus.btn_prev, bus.btn_next, bus.btn_vdn, bus.btn_vup} = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_volume"}, bus.volume, 32'h8080);
    chk({tag, "_current"}, bus.current, 32'h0);
    chk({tag, "_accept"}, bus.cmd_accept, 32'h0);
    chk({tag, "_busy"}, bus.busy, 32'h0);
    chk({tag, "_drop"}, bus.bt_drop, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    bus.bt_valid = 1'b0;
    bus.bt_data  = '0;
    {bus.btn_prev, bus.btn_next, bus.btn_vdn, bus.btn_vup} = '0;
    #12;
    chk_reset_vals("rst0");
    #10 rst = 1'b1;
    cmp_en = 1'b1;
    tick(1);

    // Single VOL_UP over Bluetooth.
    acc_cnt = 0; busy_cnt = 0;
    bt(8'hB4);
    tick(20);
    chk("a_accepts", acc_cnt, 1);
    chk("a_busy_cycles", busy_cnt, 10);
    chk("a_volume", bus.volume, 32'h9090);

    // NEXT wraps 4->0; PREV queued during HOLD wraps back to 4.
    bt(8'h04);
    tick(15);
    chk("b_sel4", bus.current, 4);
    bt(8'hB2);
    tick(4);
    chk("b_next_wrap", bus.current, 0);
    btn(0);
    chk("b_held", bus.current, 0);
    tick(12);
    chk("b_prev_wrap", bus.current, 4);
    tick(10);

    // Saturating VOL_UP still produces an accept.
    repeat (6) begin
      btn(3);
      tick(12);
    end
    chk("c_vol_max", bus.volume, 32'hF0F0);
    acc_cnt = 0;
    bt(8'hB4);
    tick(14);
    chk("c_vol_sat", bus.volume, 32'hF0F0);
    chk("c_sat_accept", acc_cnt, 1);

    // Overflow the FIFO during HOLD; out-of-range byte is ignored silently.
    acc_cnt = 0; drop_cnt = 0;
    bt(8'h02);
    tick(2);
    repeat (6) bt(8'h01);
    bt(8'h07);
    chk("d_drops", drop_cnt, 2);
    tick(60);
    chk("d_accepts", acc_cnt, 5);
    chk("d_current", bus.current, 1);
    chk("d_drops_final", drop_cnt, 2);

    // Button vs FIFO arbitration.
    repeat (2) begin
      btn(2);
      tick(12);
    end
    chk("e_vol_start", bus.volume, 32'hD0D0);
    bt(8'h00);
    bt(8'hB3);
    btn(3);
    tick(12);
    chk("e_first_btn", bus.volume, 32'hE0E0);
    btn(3);
    tick(12);
    chk("e_second", bus.volume, RrEn ? 32'hD0D0 : 32'hF0F0);
    tick(12);
    chk("e_final", bus.volume, 32'hE0E0);
    tick(10);

    // Reset in the middle of HOLD with three commands queued.
    bt(8'h03);
    repeat (3) bt(8'hB2);
    tick(2);
    chk("f_in_hold", bus.busy, 1);
    rst = 1'b0;
    #1;
    chk_reset_vals("f_rst");
    tick(2);
    #4 rst = 1'b1;
    acc_cnt = 0;
    tick(30);
    chk("f_no_accept", acc_cnt, 0);
    chk("f_volume", bus.volume, 32'h8080);
    chk("f_current", bus.current, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
